reg_writeback: RTL and testbench
================================

# reg_writeback

Write-side driver for the integer register file: accepts single-cycle ALU results and multi-cycle memory loads and turns both into one registered register-file write port (`rd_addr`, `rd_data`, `reg_write_enable`).
- Tracks the outstanding load in a 32-bit busy scoreboard so the decode stage can detect hazards on the pending destination.
- Performs RV32I load byte/halfword extraction and sign/zero extension.
- Sits between the execute/memory stages and the register file.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles waited for load data before abort. Used only with `WB_LOAD_TIMEOUT_EN`; range 1..65535.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_result` in 32: ALU result value.
- `alu_ready` out 1: ALU result accepted when `alu_valid && alu_ready`.
- `load_issue_valid` in 1: load request offered.
- `load_issue_rd` in 5: load destination register.
- `load_issue_funct3` in 3: RV32I load funct3.
- `load_issue_offset` in 2: byte address bits [1:0].
- `load_issue_ready` out 1: load request accepted when `load_issue_valid && load_issue_ready`.
- `mem_read_valid` in 1: load data present this cycle.
- `mem_read_data` in 32: raw aligned memory word.
- `rd_addr` out 5: register-file write address.
- `rd_data` out 32: register-file write data.
- `reg_write_enable` out 1: register-file write strobe.
- `busy_mask` out 32: bit i = 1 while a load to register i is outstanding. Bit 0 is always 0.
- `load_error` out 1: one-cycle pulse on load timeout. Constant 0 without the macro.

## Operation
- FSM has two states: IDLE and WAIT_MEM. The state register, load rd/funct3/offset, and the output registers are all clocked.
- `load_issue_ready = (state == IDLE) && !reset`.
- On load accept:
  - capture rd, funct3 and offset; go to WAIT_MEM;
  - set `busy_mask[load_issue_rd]` unless rd = 0.
- `mem_read_valid` is ignored in IDLE.
- In WAIT_MEM with `mem_read_valid`:
  - extract the result and register it to the outputs;
  - `reg_write_enable = (rd != 0)`;
  - clear the busy bit; return to IDLE.
- Extraction rules:
  - funct3 000 LB: byte `offset`, sign-extended.
  - funct3 100 LBU: byte `offset`, zero-extended.
  - funct3 001 LH: halfword `offset[1]`, sign-extended.
  - funct3 101 LHU: halfword `offset[1]`, zero-extended.
  - funct3 010 LW: full word, offset ignored.
  - Reserved 011/110/111 are treated as LW. `offset[0]` is ignored for halfwords; there is no misalignment trap.
- `alu_ready` is 0 when any of these holds:
  - `reset`;
  - `state == WAIT_MEM && mem_read_valid` (the load owns the write port);
  - `alu_rd != 0 && busy_mask[alu_rd]` (WAW hazard on the pending load).
- On ALU accept: the outputs take `alu_rd`/`alu_result`, and `reg_write_enable = (alu_rd != 0)`.
- With no accepted write in a cycle, `reg_write_enable` is 0 the next cycle. `rd_addr`/`rd_data` hold their last values.
- ALU accept and load issue may both occur in the same IDLE cycle, even with the same rd. The ALU hazard check uses the pre-update `busy_mask`, so the ALU write lands first and the load writes later (program order).
- rd = 0 is never written and never marked busy.

## Timing
- ALU accepted in cycle N → write strobe in cycle N+1.
- Load accepted in cycle N → state WAIT_MEM from N+1; earliest data in N+1.
- `busy_mask` bit is visible from N+1.
- `mem_read_valid` in cycle M → write strobe, busy-bit clear, IDLE and `load_issue_ready = 1`, all in cycle M+1.
- Back-to-back loads: next issue is accepted in M+1 at the earliest.
- Reset, including mid-WAIT_MEM:
  - state IDLE, `busy_mask = 0`, `rd_addr = 0`, `rd_data = 0`, `reg_write_enable = 0`, `load_error = 0`;
  - `alu_ready = 0` and `load_issue_ready = 0` while `reset` is high;
  - the pending load is dropped, and late `mem_read_valid` after reset is ignored (state is IDLE).

## Configuration
- Macro `WB_LOAD_TIMEOUT_EN`. When defined:
  - a 16-bit counter clears on load accept and increments each WAIT_MEM cycle without `mem_read_valid`;
  - on the cycle the count reaches `TIMEOUT_CYCLES` with no data: return to IDLE, clear the busy bit, no register write, `load_error = 1` for one cycle in the next cycle;
  - data arriving in the same cycle as the timeout wins: a normal write, no error.
- When undefined:
  - no counter; WAIT_MEM persists until data arrives or reset;
  - `load_error` is tied to 0.

## Test plan
- **ALU write:** ALU accept, rd = 5, result 0xDEADBEEF, in cycle N → N+1: `reg_write_enable = 1`, `rd_addr = 5`, `rd_data = 0xDEADBEEF`. Same with rd = 0 → `reg_write_enable = 0`.
- **Load extraction:** load to rd = 7 with `mem_read_data = 0x80FF7F01`:
  - LB offset 3 → 0xFFFFFF80;
  - LBU offset 1 → 0x0000007F;
  - LH offset 2 → 0xFFFF80FF;
  - LHU offset 0 → 0x00007F01;
  - LW → 0x80FF7F01.
  - In each case `busy_mask[7]` is 1 from issue+1 until the write cycle.
- **WAW hazard:** load pending to rd = 9, `alu_valid` with rd = 9 → `alu_ready = 0` until data arrives. ALU to rd = 10 during the wait → accepted.
- **Port conflict:** `mem_read_valid` and `alu_valid` in the same WAIT_MEM cycle → `alu_ready = 0`, load written at M+1, ALU written at M+2.
- **Reset mid-load:** `reset` asserted in WAIT_MEM → `busy_mask = 0`, IDLE. A following `mem_read_valid` produces no write.
- **Timeout (macro defined, `TIMEOUT_CYCLES = 4`):** load with no data → after 4 wait cycles `load_error` pulses once, busy bit clears, `load_issue_ready = 1`, no write.

Source files
------------

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and RV32I loads into one registered register-file write port.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module reg_writeback #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        load_issue_valid,
    input  logic [4:0]  load_issue_rd,
    input  logic [2:0]  load_issue_funct3,
    input  logic [1:0]  load_issue_offset,
    output logic        load_issue_ready,
    input  logic        mem_read_valid,
    input  logic [31:0] mem_read_data,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        reg_write_enable,
    output logic [31:0] busy_mask,
    output logic        load_error
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_n;
    logic [4:0] ld_rd, ld_rd_n, rd_addr_n;
    logic [2:0] ld_f3, ld_f3_n;
    logic [1:0] ld_off, ld_off_n;
    logic [31:0] busy_n, rd_data_n, ld_val;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic we_n, mem_hit, load_acc, alu_acc, timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    assign load_issue_ready = (state == IDLE) && !reset;
    assign load_acc = load_issue_valid && load_issue_ready;
    assign mem_hit = (state == WAIT_MEM) && mem_read_valid;
    // The ALU hazard check deliberately sees the pre-update busy mask.
    assign alu_ready = !reset && !mem_hit && !(alu_rd != 5'd0 && busy_mask[alu_rd]);
    assign alu_acc = alu_valid && alu_ready;
    assign byte_v = 8'(mem_read_data >> {ld_off, 3'b000});
    assign half_v = ld_off[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    assign ld_val = ld_f3[1:0] == 2'b00 ? {{24{~ld_f3[2] & byte_v[7]}}, byte_v} :
                    ld_f3[1:0] == 2'b01 ? {{16{~ld_f3[2] & half_v[15]}}, half_v} : mem_read_data;

`ifdef WB_LOAD_TIMEOUT_EN
    logic [15:0] cnt, cnt_n;
    assign timeout = (state == WAIT_MEM) && !mem_read_valid && (cnt + 16'd1 == 16'(TIMEOUT_CYCLES));
    assign cnt_n = load_acc ? 16'd0 : (state == WAIT_MEM && !mem_read_valid) ? cnt + 16'd1 : cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 16'd0;
            load_error <= 1'b0;
        end else begin
            cnt <= cnt_n;
            load_error <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign load_error = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ld_rd_n = ld_rd;
        ld_f3_n = ld_f3;
        ld_off_n = ld_off;
        busy_n = busy_mask;
        rd_addr_n = rd_addr;
        rd_data_n = rd_data;
        we_n = 1'b0;
        if (load_acc) begin
            state_n = WAIT_MEM;
            ld_rd_n = load_issue_rd;
            ld_f3_n = load_issue_funct3;
            ld_off_n = load_issue_offset;
            busy_n[load_issue_rd] = 1'b1;
        end
        if (mem_hit || timeout) begin
            state_n = IDLE;
            busy_n[ld_rd] = 1'b0;
        end
        if (mem_hit) begin
            rd_addr_n = ld_rd;
            rd_data_n = ld_val;
            we_n = ld_rd != 5'd0;
        end else if (alu_acc) begin
            rd_addr_n = alu_rd;
            rd_data_n = alu_result;
            we_n = alu_rd != 5'd0;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ld_rd <= 5'd0;
            ld_f3 <= 3'd0;
            ld_off <= 2'd0;
            busy_mask <= 32'd0;
            rd_addr <= 5'd0;
            rd_data <= 32'd0;
            reg_write_enable <= 1'b0;
        end else begin
            state <= state_n;
            ld_rd <= ld_rd_n;
            ld_f3 <= ld_f3_n;
            ld_off <= ld_off_n;
            busy_mask <= busy_n;
            rd_addr <= rd_addr_n;
            rd_data <= rd_data_n;
            reg_write_enable <= we_n;
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and random stimulus against a transaction-level model of reg_writeback.
module tb_reg_writeback;
    localparam int TO = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic alu_valid = 1'b0, load_issue_valid = 1'b0, mem_read_valid = 1'b0;
    logic [4:0] alu_rd = 5'd0, load_issue_rd = 5'd0, rd_addr;
    logic [31:0] alu_result = 32'd0, mem_read_data = 32'd0, rd_data, busy_mask;
    logic [2:0] load_issue_funct3 = 3'd0;
    logic [1:0] load_issue_offset = 2'd0;
    logic alu_ready, load_issue_ready, reg_write_enable, load_error;
    int n_vec = 0, n_bad = 0;

    bit pend = 1'b0;
    logic [4:0] prd = 5'd0, e_addr = 5'd0;
    logic [2:0] pf3 = 3'd0;
    logic [1:0] poff = 2'd0;
    logic [31:0] e_data = 32'd0;
    bit e_we = 1'b0, e_err = 1'b0;
    int waited = 0;

    reg_writeback #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .load_issue_valid(load_issue_valid), .load_issue_rd(load_issue_rd),
        .load_issue_funct3(load_issue_funct3), .load_issue_offset(load_issue_offset),
        .load_issue_ready(load_issue_ready),
        .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write_enable(reg_write_enable),
        .busy_mask(busy_mask), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] o, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * o)) & 32'hFF;
        h = (d >> (16 * o[1])) & 32'hFFFF;
        case (f)
            3'd0: return b >= 128 ? b | 32'hFFFFFF00 : b;
            3'd4: return b;
            3'd1: return h >= 32768 ? h | 32'hFFFF0000 : h;
            3'd5: return h;
            default: return d;
        endcase
    endfunction

    task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ares,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] lf3, input logic [1:0] loff,
                        input bit mv, input logic [31:0] md);
        logic [31:0] busy;
        bit e_ar, e_lr, alu_take, load_take;
        @(negedge clk);
        reset = r; alu_valid = av; alu_rd = ard; alu_result = ares;
        load_issue_valid = lv; load_issue_rd = lrd; load_issue_funct3 = lf3; load_issue_offset = loff;
        mem_read_valid = mv; mem_read_data = md;
        #1;
        busy = (pend && prd != 0) ? (32'd1 << prd) : 32'd0;
        e_lr = !r && !pend;
        e_ar = !r && !(pend && mv) && !(ard != 0 && busy[ard]);
        check("rd_addr", {27'd0, rd_addr}, {27'd0, e_addr});
        check("rd_data", rd_data, e_data);
        check("we", {31'd0, reg_write_enable}, {31'd0, e_we});
        check("busy_mask", busy_mask, busy);
        check("load_error", {31'd0, load_error}, {31'd0, e_err});
        check("alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
        check("load_ready", {31'd0, load_issue_ready}, {31'd0, e_lr});
        alu_take = av && e_ar;
        load_take = lv && e_lr;
        e_we = 1'b0;
        e_err = 1'b0;
        if (r) begin
            pend = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        end else begin
            if (pend && mv) begin
                e_addr = prd; e_data = extract(pf3, poff, md); e_we = prd != 0; pend = 1'b0;
            end else if (alu_take) begin
                e_addr = ard; e_data = ares; e_we = ard != 0;
            end
`ifdef WB_LOAD_TIMEOUT_EN
            if (pend && !mv) begin
                waited++;
                if (waited == TO) begin
                    pend = 1'b0; e_err = 1'b1;
                end
            end
`endif
            if (load_take) begin
                pend = 1'b1; prd = lrd; pf3 = lf3; poff = loff; waited = 0;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [2:0] tf3 [5];
    logic [1:0] toff [5];
    logic [31:0] texp [5];

    initial begin
        tf3 = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        toff = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
        texp = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("alu5_we", {31'd0, reg_write_enable}, 32'd1);
        check("alu5_data", rd_data, 32'hDEADBEEF);
        step(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("alu0_we", {31'd0, reg_write_enable}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 7, tf3[i], toff[i], 0, 0);
            idle();
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF7F01);
            @(posedge clk); #1;
            check("load_ext", rd_data, texp[i]);
        end
        step(0, 0, 0, 0, 1, 9, 3'd2, 0, 0, 0);
        step(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
        step(0, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 9, 32'h99, 0, 0, 0, 0, 1, 32'hCAFE0009);
        step(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        step(0, 0, 0, 0, 1, 3, 3'd2, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
        idle();
        idle();
        step(0, 0, 0, 0, 1, 4, 3'd2, 0, 0, 0);
        repeat (7) idle();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 3'($urandom), 2'($urandom),
                 $urandom_range(0, 9) < 3, $urandom);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
